// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD controller slice.
// Holds the binary-encoded FSM state type and the iteration counter width.
package gcd_pkg;

   localparam int ITER_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CALC   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // True when exactly one comparator flag is set; anything else terminates CALC.
   function automatic logic flags_one_hot(input logic lt, input logic gt, input logic eq);
      return (lt ^ gt ^ eq) & ~(lt & gt & eq);
   endfunction

endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtraction counter: cleared on an accepted start, counts each subtraction,
// saturates at MAX_ITER and flags the terminal value.
module gcd_iter_cnt
   import gcd_pkg::*;
#(
   parameter int MAX_ITER = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [ITER_W-1:0] cnt,
   output logic              at_max
);

   localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);

   logic [ITER_W-1:0] cnt_r;

   // Count register with saturation at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {ITER_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {ITER_W{1'b0}};
      end else if (inc && (cnt_r != LIMIT)) begin
         cnt_r <= cnt_r + ITER_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt    = cnt_r;
   assign at_max = (cnt_r == LIMIT);

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath: sequences operand loads,
// steers the subtractor muxes and aborts when the iteration limit is hit.
module gcd_controller
   import gcd_pkg::*;
#(
   parameter int MAX_ITER = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              data_valid,
   input  logic              lt,
   input  logic              gt,
   input  logic              eq,
   output logic              data_req,
   output logic              ldA,
   output logic              ldB,
   output logic              sel1,
   output logic              sel2,
   output logic              sel_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ITER_W-1:0] iter_cnt
);

   state_t state_r;
   state_t next_state_s;
   logic   abort_r;
   logic   abort_set_s;
   logic   cnt_clr_s;
   logic   cnt_inc_s;
   logic   at_max_s;

   gcd_iter_cnt #(
      .MAX_ITER (MAX_ITER)
   ) u_iter_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr_s),
      .inc    (cnt_inc_s),
      .cnt    (iter_cnt),
      .at_max (at_max_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Abort flag: remembered from the limit hit in CALC until the next accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         abort_r <= 1'b0;
      end else if (cnt_clr_s) begin
         abort_r <= 1'b0;
      end else if (abort_set_s) begin
         abort_r <= 1'b1;
      end else begin
         abort_r <= abort_r;
      end
   end

   // Next-state and output decode.
   always_comb begin
      next_state_s = state_r;
      data_req     = 1'b0;
      ldA          = 1'b0;
      ldB          = 1'b0;
      sel1         = 1'b0;
      sel2         = 1'b0;
      sel_in       = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      abort_set_s  = 1'b0;
      cnt_clr_s    = 1'b0;
      cnt_inc_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = LOAD_A;
               cnt_clr_s    = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOAD_A: begin
            data_req = 1'b1;
            if (data_valid) begin
               ldA          = 1'b1;
               next_state_s = LOAD_B;
            end else begin
               next_state_s = LOAD_A;
            end
         end
         LOAD_B: begin
            data_req = 1'b1;
            if (data_valid) begin
               ldB          = 1'b1;
               next_state_s = CALC;
            end else begin
               next_state_s = LOAD_B;
            end
         end
         CALC: begin
            // Equality wins over the limit so a result found on the last allowed step is clean.
            if (eq || !flags_one_hot(lt, gt, eq)) begin
               next_state_s = DONE;
            end else if (at_max_s) begin
               next_state_s = DONE;
               abort_set_s  = 1'b1;
            end else if (gt) begin
               sel1      = 1'b1;
               sel_in    = 1'b1;
               ldA       = 1'b1;
               cnt_inc_s = 1'b1;
            end else begin
               sel2      = 1'b1;
               sel_in    = 1'b1;
               ldB       = 1'b1;
               cnt_inc_s = 1'b1;
            end
         end
         DONE: begin
            done         = 1'b1;
            err          = abort_r;
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
      busy = (state_r != IDLE);
   end

endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench: the controller drives a behavioural datapath; results are
// compared with a table of hand-derived vectors and a plain-arithmetic GCD model.
module tb_gcd_controller;

   localparam int MAXI = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        data_valid = 1'b0;
   logic        lt, gt, eq;
   logic        data_req, ldA, ldB, sel1, sel2, sel_in, busy, done, err;
   logic [15:0] iter_cnt;
   logic [7:0]  data_in = 8'd0;
   logic [7:0]  reg_a = 8'd0;
   logic [7:0]  reg_b = 8'd0;
   logic [7:0]  op1, op2, bus;
   logic        flag_ovr = 1'b0;
   logic [2:0]  ovr_flags = 3'b110;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   gcd_controller #(.MAX_ITER(MAXI)) dut (
      .clk(clk), .rst(rst), .start(start), .data_valid(data_valid),
      .lt(lt), .gt(gt), .eq(eq),
      .data_req(data_req), .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2),
      .sel_in(sel_in), .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
   );

   // Behavioural datapath: two registers, subtractor with operand muxes, bus mux.
   assign op1 = sel1 ? reg_a : reg_b;
   assign op2 = sel2 ? reg_a : reg_b;
   assign bus = sel_in ? (op1 - op2) : data_in;
   assign lt  = flag_ovr ? ovr_flags[2] : (reg_a < reg_b);
   assign gt  = flag_ovr ? ovr_flags[1] : (reg_a > reg_b);
   assign eq  = flag_ovr ? ovr_flags[0] : (reg_a == reg_b);

   always @(posedge clk) begin
      if (ldA) reg_a <= bus;
      if (ldB) reg_b <= bus;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Euclid by repeated subtraction, stopping once MAXI subtractions are used up.
   function automatic void ref_gcd(input int a, input int b, output int res, output int n, output int e);
      n = 0;
      e = 0;
      while (a != b) begin
         if (n == MAXI) begin
            e = 1;
            break;
         end
         if (a > b) a = a - b;
         else b = b - a;
         n++;
      end
      res = a;
   endfunction

   // One computation: start in cycle 0, feed operands on data_req, report done cycle.
   task automatic run_gcd(input int a, input int b, input int stall_b, input int strt_cyc,
                          input int ovr_cyc, input int rst_cyc,
                          output int res, output int n, output int e, output int dcyc);
      int  loads = 0;
      int  stall = stall_b;
      int  cyc = 0;
      bit  fin = 1'b0;
      res = -1; n = -1; e = -1; dcyc = -1;
      @(negedge clk);
      start = 1'b1;
      data_valid = 1'b0;
      while (!fin && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = (cyc == strt_cyc);
         flag_ovr = (cyc == ovr_cyc);
         rst = (cyc == rst_cyc);
         data_valid = 1'b0;
         if (data_req) begin
            if (loads == 1 && stall > 0) begin
               stall--;
            end else begin
               data_valid = 1'b1;
               data_in = (loads == 0) ? 8'(a) : 8'(b);
            end
         end
         #1;
         chk("ld_exclusive", int'(ldA && ldB), 0);
         if (data_req && !data_valid) chk("stall_no_load", int'(ldA || ldB), 0);
         if (data_valid) loads++;
         if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
            chk("post_rst_outs", int'({data_req, ldA, ldB, sel1, sel2, sel_in, busy, done, err}), 0);
            chk("post_rst_iter", int'(iter_cnt), 0);
            fin = 1'b1;
            dcyc = -2;
         end else if (done) begin
            dcyc = cyc;
            res = int'(reg_a);
            n = int'(iter_cnt);
            e = int'(err);
            fin = 1'b1;
         end
      end
      if (!fin) chk("done_timeout", cyc, -1);
      @(negedge clk);
      start = 1'b0; flag_ovr = 1'b0; rst = 1'b0; data_valid = 1'b0;
      #1;
      chk("after_done_busy", int'(busy), 0);
      chk("done_one_cycle", int'(done), 0);
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("no_extra_done", int'(done), 0);
      end
   endtask

   typedef struct {
      int a; int b; int stall; int strt; int ovr;
      int res; int n; int e; int dc;
   } vec_t;

   vec_t vt[11];

   initial begin
      int res, n, e, dc, ra, rb, er, en, ee;

      vt[0]  = '{48, 18, 0, 0, 0,  6,  4, 0,  8};
      vt[1]  = '{ 7,  7, 0, 0, 0,  7,  0, 0,  4};
      vt[2]  = '{ 0,  5, 0, 0, 0, -1, 16, 1, 20};
      vt[3]  = '{48, 18, 3, 0, 0,  6,  4, 0, 11};
      vt[4]  = '{ 9,  6, 0, 0, 0,  3,  2, 0,  6};
      vt[5]  = '{ 5,  0, 0, 0, 0, -1, 16, 1, 20};
      vt[6]  = '{ 1, 17, 0, 0, 0,  1, 16, 0, 20};
      vt[7]  = '{ 1, 18, 0, 0, 0, -1, 16, 1, 20};
      vt[8]  = '{48, 18, 0, 5, 0,  6,  4, 0,  8};
      vt[9]  = '{48, 18, 0, 8, 0,  6,  4, 0,  8};
      vt[10] = '{48, 18, 0, 0, 3, 48,  0, 0,  4};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_outs", int'({data_req, ldA, ldB, sel1, sel2, sel_in, busy, done, err}), 0);
      chk("reset_iter", int'(iter_cnt), 0);

      for (int i = 0; i < 11; i++) begin
         run_gcd(vt[i].a, vt[i].b, vt[i].stall, vt[i].strt, vt[i].ovr, 0, res, n, e, dc);
         if (vt[i].res >= 0) chk($sformatf("vec%0d_result", i), res, vt[i].res);
         chk($sformatf("vec%0d_iter", i), n, vt[i].n);
         chk($sformatf("vec%0d_err", i), e, vt[i].e);
         chk($sformatf("vec%0d_done_cycle", i), dc, vt[i].dc);
         chk($sformatf("vec%0d_iter_hold", i), int'(iter_cnt), vt[i].n);
      end

      // Reset during the second CALC cycle, then a fresh computation.
      run_gcd(48, 18, 0, 0, 0, 4, res, n, e, dc);
      chk("rst_mid_calc", dc, -2);
      run_gcd(9, 6, 0, 0, 0, 0, res, n, e, dc);
      chk("after_rst_result", res, 3);
      chk("after_rst_iter", n, 2);
      chk("after_rst_cycle", dc, 6);

      for (int k = 0; k < 30; k++) begin
         ra = int'($urandom_range(1, 40));
         rb = int'($urandom_range(1, 40));
         ref_gcd(ra, rb, er, en, ee);
         run_gcd(ra, rb, 0, 0, 0, 0, res, n, e, dc);
         if (ee == 0) chk($sformatf("rnd_%0d_%0d_result", ra, rb), res, er);
         chk($sformatf("rnd_%0d_%0d_iter", ra, rb), n, en);
         chk($sformatf("rnd_%0d_%0d_err", ra, rb), e, ee);
         chk($sformatf("rnd_%0d_%0d_cycle", ra, rb), dc, 4 + en);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter MAX_ITER, default 65535: maximum number of subtraction cycles allowed per computation before error abort.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock, shared with the GCD datapath.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request to begin a computation; honoured only in IDLE.
REQ-006 data_valid  input  1  operand present on the datapath data_in bus this cycle.
REQ-007 lt, gt, eq  input  1 each  datapath comparator flags for A<B, A>B and A==B.
REQ-008 data_req  output  1  controller is waiting for an operand (asserted in LOAD_A and LOAD_B).
REQ-009 ldA, ldB  output  1 each  datapath register load enables.
REQ-010 sel1, sel2  output  1 each  subtractor operand mux selects (1 = A, 0 = B).
REQ-011 sel_in  output  1  bus mux select (1 = subtractor result, 0 = data_in).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; the GCD is valid in register A.
REQ-014 err  output  1  one-cycle pulse, coincident with done, on iteration-limit abort.
REQ-015 iter_cnt  output  16  number of subtractions performed in the current/last computation.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, CALC and DONE.
REQ-017 IDLE: all load enables low; start=1 -> LOAD_A, and iter_cnt is cleared to 0 on the same edge.
REQ-018 LOAD_A: data_req=1; on data_valid=1 -> sel_in=0, ldA=1, next state LOAD_B; otherwise hold with ldA=0.
REQ-019 LOAD_B: as in LOAD_A but asserting ldB; on data_valid=1 -> CALC.
REQ-020 CALC with eq=1 -> no load, next state DONE.
REQ-021 CALC with gt=1 -> sel1=1, sel2=0, sel_in=1, ldA=1 (A <= A-B), iter_cnt+1.
REQ-022 CALC with lt=1 -> sel1=0, sel2=1, sel_in=1, ldB=1 (B <= B-A), iter_cnt+1.
REQ-023 CALC with iter_cnt==MAX_ITER and eq=0 -> no load; DONE is entered with the err flag set.
REQ-024 DONE: done=1 for exactly one cycle, err=1 if the abort flag is set; next state IDLE.
REQ-025 Outputs are decoded combinationally from state and flags; at most one of ldA/ldB is high in any cycle.
REQ-026 Latency with data_valid held high: the start edge is cycle 0, the operand loads occur in cycles 1-2, and done is high in cycle 4+N for N subtractions.
REQ-027 start outside IDLE SHALL be ignored, including in the DONE cycle.
REQ-028 iter_cnt saturates at MAX_ITER and holds its value after DONE until the next accepted start.
REQ-029 Flag combinations other than exactly one hot in CALC are treated as eq (terminate).

Reset
REQ-030 rst=1 at any clock edge, including mid-CALC, -> IDLE, iter_cnt=0, abort flag cleared.
REQ-031 In the cycle after reset: done=err=busy=data_req=ldA=ldB=0; sel1, sel2 and sel_in are don't-care but driven to 0.
REQ-032 Reset takes priority over start.

Structure
REQ-033 Package gcd_pkg SHALL hold the state typedef (5 states, binary encoding) and the ITER_W=16 constant.
REQ-034 The iteration counter (clear, increment, saturate, terminal flag) SHALL be one sub-module, gcd_iter_cnt.
REQ-035 The top level SHALL be connectable to the existing datapath without glue logic.

Verification
REQ-036 A=48, B=18, data_valid=1 -> 4 subtractions (30,18; 12,18; 12,6; 6,6), done in cycle 8, A=6, iter_cnt=4, err=0.
REQ-037 A=7, B=7 -> no subtraction, done in cycle 4, iter_cnt=0.
REQ-038 MAX_ITER=16, A=0, B=5 -> 16 ldB cycles, then done=err=1 in cycle 20, iter_cnt=16.
REQ-039 data_valid low for 3 cycles in LOAD_B -> data_req stays high and ldB=0; the operand loads on the first valid cycle and done shifts by +3.
REQ-040 rst in the 2nd CALC cycle of 48/18 -> next cycle IDLE, all outputs 0; a new start with 9/6 -> A=3.
REQ-041 start pulsed during CALC -> ignored; only one done pulse, with the original result.
